// File: rtl/pla_eval_pipe.sv
// rtl/pla_eval_pipe.sv - pipelined runtime-programmable sum-of-products evaluator
module pla_eval_pipe #(
  parameter  int NUM_IN    = 8,
  parameter  int NUM_OUT   = 7,
  parameter  int NUM_TERMS = 32,
  localparam int AW        = $clog2(NUM_TERMS),
  localparam int CW        = 2*NUM_IN + NUM_OUT + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [CW-1:0]      cfg_data,
  output logic               cfg_busy,
  output logic               cfg_err,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_IN-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_data,
  output logic [15:0]        out_count
);

  // Cube table: one AND-plane mask/value pair, OR-plane row and enable per slot.
  logic [NUM_IN-1:0]    mask_q [NUM_TERMS];
  logic [NUM_IN-1:0]    val_q  [NUM_TERMS];
  logic [NUM_OUT-1:0]   or_q   [NUM_TERMS];
  logic [NUM_TERMS-1:0] en_q;

  // Pipeline state.
  logic               s1_valid_q, s1_valid_d;
  logic [NUM_IN-1:0]  s1_data_q,  s1_data_d;
  logic               s2_valid_q, s2_valid_d;
  logic [NUM_OUT-1:0] s2_data_q,  s2_data_d;
  logic [15:0]        count_q,    count_d;
  logic               err_q,      err_d;

  // Handshake and config decode.
  logic               advance;
  logic               accept;
  logic               s1_move;
  logic               out_fire;
  logic               addr_ok;
  logic               cfg_do;
  logic [NUM_OUT-1:0] sop;

  logic [NUM_IN-1:0]  cfg_mask;
  logic [NUM_IN-1:0]  cfg_val;
  logic [NUM_OUT-1:0] cfg_or;
  logic               cfg_en;

  // Config word layout, LSB first: mask, val, or_bits, en.
  assign cfg_mask = cfg_data[NUM_IN-1:0];
  assign cfg_val  = cfg_data[2*NUM_IN-1:NUM_IN];
  assign cfg_or   = cfg_data[2*NUM_IN+NUM_OUT-1:2*NUM_IN];
  assign cfg_en   = cfg_data[CW-1];

  // S2 drains whenever it is empty or the consumer takes its result.
  assign advance  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || advance;
  assign accept   = in_valid && in_ready;
  assign s1_move  = s1_valid_q && advance;
  assign out_fire = s2_valid_q && out_ready;

  // Table is only written with an empty pipeline, so every in-flight vector
  // sees one consistent table image. Address widened by one bit so that
  // non power-of-two slot counts can be range-checked.
  assign cfg_busy = s1_valid_q || s2_valid_q;
  assign addr_ok  = ({1'b0, cfg_addr} < (AW+1)'(NUM_TERMS));
  assign cfg_do   = cfg_we && !cfg_busy && addr_ok;

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_count = count_q;
  assign cfg_err   = err_q;

  // Sum-of-products over the S1 vector: OR together rows of all matching cubes.
  always_comb begin
    sop = '0;
    for (int t = 0; t < NUM_TERMS; t++) begin
      if (en_q[t] && (((s1_data_q ^ val_q[t]) & mask_q[t]) == '0)) begin
        sop = sop | or_q[t];
      end
    end
  end

  // Next-state for both pipeline stages, the output counter and the error pulse.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    count_d    = count_q;
    err_d      = cfg_we && !cfg_do;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end

    // When S2 may advance it takes whatever S1 holds (possibly a bubble),
    // which also covers the same-cycle drain-and-reload case.
    if (advance) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_move) begin
      s2_data_d = sop;
    end

    if (out_fire) begin
      count_d = count_q + 16'd1;
    end
  end

  // Pipeline, counter and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  // Term table storage; reset leaves every slot disabled and zeroed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_TERMS; t++) begin
        mask_q[t] <= '0;
        val_q[t]  <= '0;
        or_q[t]   <= '0;
      end
      en_q <= '0;
    end else if (cfg_do) begin
      mask_q[cfg_addr] <= cfg_mask;
      val_q[cfg_addr]  <= cfg_val;
      or_q[cfg_addr]   <= cfg_or;
      en_q[cfg_addr]   <= cfg_en;
    end
  end

endmodule

// File: doc/pla_eval_pipe.md
Name: pla_eval_pipe

Overview:
- Runtime-programmable, pipelined sum-of-products (PLA) evaluator with generic input, output and term counts.
- Loads a cube table (AND-plane mask/value, OR-plane bits, enable) through a config port.
- Evaluates input vectors under a valid/ready handshake with a fixed 2-cycle latency.
- Lets the team replay any two-level benchmark netlist (e.g. an 8-in/7-out control PLA) in hardware without resynthesis.

Parameters:
- NUM_IN, 8, number of primary inputs (1..32).
- NUM_OUT, 7, number of primary outputs (1..32).
- NUM_TERMS, 32, number of product-term slots (2..256, power of two not required).
- AW, $clog2(NUM_TERMS), config address width (derived, not overridden).
- CW, 2*NUM_IN+NUM_OUT+1, config word width (derived).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_we  in  1  term-write strobe.
- cfg_addr  in  AW  term slot index.
- cfg_data  in  CW  {en, or_bits[NUM_OUT], val[NUM_IN], mask[NUM_IN]}, mask in LSBs.
- cfg_busy  out  1  high while any pipeline stage holds data; writes are refused.
- cfg_err  out  1  one-cycle pulse on a refused or out-of-range write.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept the vector this cycle.
- in_data  in  NUM_IN  input vector; bit i = pi i.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  NUM_OUT  result; bit j = po j.
- out_count  out  16  number of completed output handshakes, wraps at 16'hFFFF->0.

Behaviour:
- Reset:
  - All term slots are cleared (en=0, mask=0, val=0, or_bits=0).
  - s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_count=0, cfg_err=0, cfg_busy=0.
  - in_ready=1 during the first cycle after reset deasserts.
  - Reset mid-transaction discards all in-flight data; no output is produced for it.
- Term match:
  - A term matches when en=1 and ((in ^ val) & mask)==0.
  - mask=0 with en=1 is a tautology term: it always matches.
- Output function: out bit j = OR over all matching terms t of or_bits_t[j]. No matching term gives 0.
- Pipeline:
  - Stage S1 registers in_data.
  - Stage S2 computes the match/OR from S1 and the term table, then registers out_data.
  - advance = !s2_valid || out_ready.
  - in_ready = !s1_valid || advance (combinational from state and out_ready).
  - An input is accepted on in_valid && in_ready and loads S1.
  - S1 moves to S2 when s1_valid && advance.
  - s1_valid clears when S1 moves without a new accept.
  - Latency: a vector accepted in cycle N gives out_valid in cycle N+2 if not stalled.
  - Throughput is 1 vector/cycle with out_ready held high.
  - While out_valid && !out_ready: out_data is held stable, S2 is frozen, and S1 may fill. in_ready falls once S1 is full.
  - Simultaneous output handshake and S1->S2 move: S2 reloads in the same cycle, so there is no bubble.
  - out_count increments on every out_valid && out_ready.
- Config:
  - cfg_busy = s1_valid || s2_valid.
  - A write is performed when cfg_we && !cfg_busy && cfg_addr < NUM_TERMS. The slot is updated at the clock edge.
  - If cfg_we is high with cfg_busy, or with an out-of-range address, the write is dropped and cfg_err pulses high the next cycle.
  - Config and input accept in the same cycle with the pipeline empty: the write is performed, and the accepted vector is evaluated against the updated table (S2 evaluates one cycle later).
  - The table is never altered while data is in flight, so results are always consistent with a single table image.

Test Plan:
- Load term0 {en=1, or=7'h01, val=8'h0E, mask=8'h0F} and term1 {en=1, or=7'h01, val=8'h05, mask=8'h0F}. Send in_data 8'h0E, 8'h05, 8'h04 back-to-back with out_ready=1 -> out_data 7'h01, 7'h01, 7'h00 in cycles N+2..N+4, and out_count=3.
- Load a tautology term {en=1, or=7'h7F, mask=0}. Send any in_data (8'hA5) -> out_data=7'h7F. Write en=0 to the same slot, then resend -> 7'h00.
- Send 3 vectors with out_ready=0 -> out_valid=1 with the first result held stable, and in_ready=0 after 2 accepts. Release out_ready -> all 3 results emerge in order with no loss or duplication.
- cfg_we while s1_valid=1 -> table unchanged and cfg_err pulses once. With NUM_TERMS=24, a write to cfg_addr=30 with the pipeline empty -> cfg_err=1 and no slot modified.
- Drive out_count to 16'hFFFF by forcing 65535 handshakes. One more handshake -> out_count=0.
- Assert rst for one cycle with both stages valid -> next cycle out_valid=0, in_ready=1, out_count=0, and all terms disabled, so any input yields 7'h00.
